// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the
// fetch port (IF) and the load/store port (DM), one access at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_wen,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic       P_IF     = 1'b0;
    localparam logic       P_DM     = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_grant;
    logic              w_gnt_port;
    logic              w_done;

    // On contention the port that did not win last time gets the memory
    assign w_gnt_port = dm_req & (~if_req | (r_last == P_IF));
    assign w_grant    = (r_state == S_IDLE) & (if_req | dm_req);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        mem_en      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en      = 1'b1;
                w_cnt_nxt   = CNT_INIT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= P_IF;
            r_last  <= P_IF;
            r_cnt   <= 4'd0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_owner <= w_gnt_port;
                r_last  <= w_gnt_port;
                r_wen   <= w_gnt_port & dm_wen;
                r_addr  <= w_gnt_port ? dm_addr : if_addr;
                r_wdata <= w_gnt_port ? dm_wdata : '0;
            end
        end
    end

    // Command registers hold past completion until the next grant
    assign mem_wen   = r_wen;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ready  = w_done & (r_owner == P_IF);
    assign dm_ready  = w_done & (r_owner == P_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tables, hand sequences and a random run
// checked against a cycle-arithmetic model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req, dm_req, dm_wen;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_wen;

    logic        x_req, z1;
    logic [31:0] x_addr, z32;
    logic [31:0] a_mrd, a_irdata, a_drdata, a_addr, a_wdata;
    logic        a_iready, a_dready, a_en, a_wen;
    logic [31:0] b_mrd, b_irdata, b_drdata, b_addr, b_wdata;
    logic        b_iready, b_dready, b_en, b_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .if_req(x_req), .if_addr(x_addr), .if_rdata(a_irdata), .if_ready(a_iready),
        .dm_req(z1), .dm_wen(z1), .dm_addr(z32), .dm_wdata(z32),
        .dm_rdata(a_drdata), .dm_ready(a_dready),
        .mem_en(a_en), .mem_wen(a_wen), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_mrd)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset),
        .if_req(x_req), .if_addr(x_addr), .if_rdata(b_irdata), .if_ready(b_iready),
        .dm_req(z1), .dm_wen(z1), .dm_addr(z32), .dm_wdata(z32),
        .dm_rdata(b_drdata), .dm_ready(b_dready),
        .mem_en(b_en), .mem_wen(b_wen), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_mrd)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h113;
    endfunction

    // Memory device: reinitialised while reset is low, read data captured
    // at the command edge and held, so it is valid by the ready cycle.
    logic [31:0] ram [0:1023];
    logic [31:0] rd;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) ram[i] <= dflt(32'(i) << 2);
        end else if (mem_en) begin
            if (mem_wen) ram[mem_addr[11:2]] <= mem_wdata;
            else rd <= ram[mem_addr[11:2]];
        end
    end
    assign mem_rdata = rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_req = 0; dm_req = 0; dm_wen = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        x_req = 0;
        reset = 0;
        #1;
        chk("reset ctl", {28'd0, mem_en, mem_wen, if_ready, dm_ready}, 32'd0);
        chk("reset addr", mem_addr, 32'd0);
        chk("reset wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    typedef struct {
        bit          first;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dd;
        bit          en;
        bit          wen;
        logic [31:0] ma;
        logic [31:0] mw;
        bit          ifr;
        bit          dmr;
        logic [31:0] rdv;
    } vec_t;

    function automatic vec_t v(bit first, bit ir, logic [31:0] ia, bit dr, bit dw,
                               logic [31:0] da, logic [31:0] dd, bit en, bit wen,
                               logic [31:0] ma, logic [31:0] mw, bit ifr, bit dmr,
                               logic [31:0] rdv);
        vec_t r;
        r.first = first; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw;
        r.da = da; r.dd = dd; r.en = en; r.wen = wen; r.ma = ma; r.mw = mw;
        r.ifr = ifr; r.dmr = dmr; r.rdv = rdv;
        return r;
    endfunction

    vec_t        tbl[$];
    int          t_free, en_c, rdy_c, e1, r1, e15, r15;
    bit          own, last, if_done, dm_done;
    bit          p_w, m_w;
    logic [31:0] p_a, p_d, m_a, m_d, exp_rd;
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        if_req = 0; dm_req = 0; dm_wen = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        x_req = 0; x_addr = 32'h100; z1 = 0; z32 = 0;
        a_mrd = 32'h0000_00A1; b_mrd = 32'h0000_00AF;

        // single fetch
        tbl.push_back(v(1, 1, 'h100, 0, 0, 0, 0, 0, 0, 'h000, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 0, 0, 1, 0, 'h100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 'h100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 'h100, 0, 1, 0, 'h13));
        tbl.push_back(v(0, 0, 'h100, 0, 0, 0, 0, 0, 0, 'h100, 0, 0, 0, 0));
        // contention after reset: DM first, then IF
        tbl.push_back(v(1, 1, 'h100, 1, 0, 'h200, 0, 0, 0, 'h000, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 1, 0, 'h200, 0, 1, 0, 'h200, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 1, 0, 'h200, 0, 0, 0, 'h200, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 1, 0, 'h200, 0, 0, 0, 'h200, 0, 0, 1, 'h313));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 'h200, 0, 0, 0, 'h200, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 'h200, 0, 1, 0, 'h100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 'h200, 0, 0, 0, 'h100, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h100, 0, 0, 'h200, 0, 0, 0, 'h100, 0, 1, 0, 'h13));
        tbl.push_back(v(0, 0, 'h100, 0, 0, 'h200, 0, 0, 0, 'h100, 0, 0, 0, 0));
        // store, then fetch back the stored word
        tbl.push_back(v(1, 0, 0, 1, 1, 'h40, 'hDEADBEEF, 0, 0, 'h00, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 'h40, 'hDEADBEEF, 1, 1, 'h40, 'hDEADBEEF, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 'h40, 'hDEADBEEF, 0, 1, 'h40, 'hDEADBEEF, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 'h40, 'hDEADBEEF, 0, 1, 'h40, 'hDEADBEEF, 0, 1, 0));
        tbl.push_back(v(0, 1, 'h40, 0, 0, 'h40, 0, 0, 1, 'h40, 'hDEADBEEF, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h40, 0, 0, 'h40, 0, 1, 0, 'h40, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h40, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 'h40, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 1, 0, 'hDEADBEEF));
        tbl.push_back(v(0, 0, 'h40, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].first) do_reset();
            @(negedge clk);
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            dm_req = tbl[i].dr; dm_wen = tbl[i].dw;
            dm_addr = tbl[i].da; dm_wdata = tbl[i].dd;
            #1;
            chk($sformatf("row%0d ctl", i), {28'd0, mem_en, mem_wen, if_ready, dm_ready},
                {28'd0, tbl[i].en, tbl[i].wen, tbl[i].ifr, tbl[i].dmr});
            chk($sformatf("row%0d addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("row%0d wdata", i), mem_wdata, tbl[i].mw);
            if (tbl[i].ifr) chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].rdv);
            if (tbl[i].dmr && !tbl[i].dw)
                chk($sformatf("row%0d dm_rdata", i), dm_rdata, tbl[i].rdv);
        end

        // both ports held: grants alternate DM, IF, DM, IF
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1; if_addr = 32'h100;
                dm_req = 1; dm_wen = 0; dm_addr = 32'h200;
            end
            if (c == 16) begin
                if_req = 0; dm_req = 0;
            end
            #1;
            chk($sformatf("alt c%0d ctl", c), {29'd0, mem_en, if_ready, dm_ready},
                {29'd0, c % 4 == 1, c % 8 == 7, c % 8 == 3});
            if (c % 4 == 1)
                chk($sformatf("alt c%0d addr", c), mem_addr,
                    (c % 8 == 1) ? 32'h200 : 32'h100);
        end

        // request dropped mid-access still completes
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                dm_req = 1; dm_wen = 0; dm_addr = 32'h200;
            end
            if (c == 1) dm_req = 0;
            #1;
            chk($sformatf("drop c%0d ctl", c), {29'd0, mem_en, if_ready, dm_ready},
                {29'd0, c == 1, 1'b0, c == 3});
        end

        // asynchronous reset in the middle of a fetch
        do_reset();
        @(negedge clk);
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        #1 chk("arst en before", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("arst ctl", {28'd0, mem_en, mem_wen, if_ready, dm_ready}, 32'd0);
        chk("arst addr", mem_addr, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("arst held", {29'd0, mem_en, if_ready, dm_ready}, 32'd0);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        #1 chk("arst reissue en", {31'd0, mem_en}, 32'd1);
        chk("arst reissue addr", mem_addr, 32'h100);
        @(negedge clk);
        @(negedge clk);
        #1 chk("arst reissue ready", {31'd0, if_ready}, 32'd1);
        @(negedge clk);
        if_req = 0;

        // LATENCY=1 and LATENCY=15 builds
        do_reset();
        e1 = -1; r1 = -1; e15 = -1; r15 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) x_req = 1;
            #1;
            if (a_en && e1 < 0) e1 = c;
            if (b_en && e15 < 0) e15 = c;
            if (a_iready && r1 < 0) begin
                r1 = c;
                chk("lat1 rdata", a_irdata, 32'hA1);
            end
            if (b_iready && r15 < 0) begin
                r15 = c;
                chk("lat15 rdata", b_irdata, 32'hAF);
            end
        end
        x_req = 0;
        chk("lat1 en cycle", 32'(e1), 32'd1);
        chk("lat1 ready cycle", 32'(r1), 32'd2);
        chk("lat15 en cycle", 32'(e15), 32'd1);
        chk("lat15 ready cycle", 32'(r15), 32'd16);

        // random traffic against a slot-timing model
        do_reset();
        ref_mem.delete();
        t_free = 0; en_c = -1; rdy_c = -1; own = 0; last = 0;
        if_done = 0; dm_done = 0;
        m_a = 0; m_d = 0; m_w = 0; p_a = 0; p_d = 0; p_w = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (if_done) begin if_req = 0; if_done = 0; end
            if (dm_done) begin dm_req = 0; dm_done = 0; end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = {20'd0, 5'($urandom_range(0, 31)), 7'd0} >> 5;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1;
                dm_wen = 1'($urandom_range(0, 1));
                dm_addr = {20'd0, 5'($urandom_range(0, 31)), 7'd0} >> 5;
                dm_wdata = $urandom;
            end
            if (k == en_c) begin
                m_a = p_a; m_w = p_w; m_d = p_d;
                if (p_w) ref_mem[p_a] = p_d;
            end
            #1;
            chk($sformatf("rnd k%0d ctl", k), {28'd0, mem_en, mem_wen, if_ready, dm_ready},
                {28'd0, k == en_c, m_w, k == rdy_c && !own, k == rdy_c && own});
            chk($sformatf("rnd k%0d addr", k), mem_addr, m_a);
            chk($sformatf("rnd k%0d wdata", k), mem_wdata, m_d);
            if (k == rdy_c) begin
                if (!p_w) begin
                    exp_rd = ref_mem.exists(p_a) ? ref_mem[p_a] : dflt(p_a);
                    chk($sformatf("rnd k%0d rdata", k), own ? dm_rdata : if_rdata, exp_rd);
                end
                if (own) dm_done = 1;
                else if_done = 1;
            end
            if (k >= t_free && (if_req || dm_req)) begin
                if (if_req && dm_req) own = ~last;
                else own = dm_req;
                last = own;
                en_c = k + 1;
                rdy_c = k + 1 + LAT;
                t_free = k + LAT + 2;
                p_a = own ? dm_addr : if_addr;
                p_w = own ? dm_wen : 1'b0;
                p_d = own ? dm_wdata : 32'd0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
